// File: rtl/vga_stack_renderer.sv
// vga_stack_renderer
//   Generates VGA timing and draws up to DEPTH hex stack entries as
//   7-segment glyphs on a CELL_W x CELL_H cell grid. Entry k sits in cell k,
//   filled left to right, top to bottom. The displayed numbers/count live in
//   shadow registers that only change at the start of vertical blanking, so
//   a visible frame never tears.
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-low
//   numbers      entry k at [k*NIB +: NIB], entry 0 = bottom of stack
//   count        number of valid entries (saturated to DEPTH on load)
//   load_req     level request to latch numbers/count at next vblank start
//   load_ack     one-cycle pulse after the latch
//   image        colour mode: 0 white-on-black, 1 black-on-blue
//   frame_start  one-cycle pulse for pixel h=0,v=0
//   vga_h_sync, vga_v_sync, vga_R/G/B   registered VGA outputs
//
// Configuration macro
//   TOS_HIGHLIGHT_EN : when defined, the top-of-stack entry (count-1) is
//                      drawn in red in both colour modes.
module vga_stack_renderer #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   DEPTH    = 15,
  parameter int   NIB      = 4,
  parameter int   CELL_W   = 32,
  parameter int   CELL_H   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DEPTH*NIB-1:0]         numbers,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         load_req,
  output logic                         load_ack,
  input  logic                         image,
  output logic                         frame_start,
  output logic                         vga_h_sync,
  output logic                         vga_v_sync,
  output logic [3:0]                   vga_R,
  output logic [3:0]                   vga_G,
  output logic [3:0]                   vga_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int COLS    = H_ACTIVE / CELL_W;
  localparam int T       = CELL_W / 8;
  localparam int MID     = CELL_H / 2;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_LOAD = VW'(V_ACTIVE);

  logic [HW-1:0]        h_cnt;
  logic [VW-1:0]        v_cnt;
  logic [DEPTH*NIB-1:0] shadow_num;
  logic [CW-1:0]        shadow_cnt;

  logic [31:0] hx, vx, col, row, k, lx, ly;
  logic        active, hs_on, vs_on, drawn, seg_on, load_now;
  logic        gx, upper, lower;
  logic [3:0]  digit;
  logic [6:0]  segs;
  logic [11:0] fg, bg, rgb;
  logic [CW-1:0] count_sat;

  // Segment bits ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_map(input logic [3:0] d);
    case (d)
      4'h0: seg_map = 7'b1111110;
      4'h1: seg_map = 7'b0110000;
      4'h2: seg_map = 7'b1101101;
      4'h3: seg_map = 7'b1111001;
      4'h4: seg_map = 7'b0110011;
      4'h5: seg_map = 7'b1011011;
      4'h6: seg_map = 7'b1011111;
      4'h7: seg_map = 7'b1110000;
      4'h8: seg_map = 7'b1111111;
      4'h9: seg_map = 7'b1111011;
      4'hA: seg_map = 7'b1110111;
      4'hB: seg_map = 7'b0011111;
      4'hC: seg_map = 7'b1001110;
      4'hD: seg_map = 7'b0111101;
      4'hE: seg_map = 7'b1001111;
      default: seg_map = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    hx     = 32'(h_cnt);
    vx     = 32'(v_cnt);
    active = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    hs_on  = (hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC);
    vs_on  = (vx >= V_ACTIVE + V_FP) && (vx < V_ACTIVE + V_FP + V_SYNC);

    col = hx / CELL_W;
    row = vx / CELL_H;
    k   = row * COLS + col;
    lx  = hx % CELL_W;
    ly  = vx % CELL_H;

    digit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (k == i) digit[NIB-1:0] = shadow_num[i*NIB +: NIB];
    end
    segs = seg_map(digit);

    // Glyph box is inset by T on every side; the middle bar is centred on MID.
    gx     = (lx >= T) && (lx < CELL_W - T);
    upper  = (ly >= T) && (ly < MID);
    lower  = (ly >= MID) && (ly < CELL_H - T);
    seg_on = (segs[6] && gx && (ly >= T) && (ly < 2*T))
          || (segs[5] && upper && (lx >= CELL_W - 2*T) && (lx < CELL_W - T))
          || (segs[4] && lower && (lx >= CELL_W - 2*T) && (lx < CELL_W - T))
          || (segs[3] && gx && (ly >= CELL_H - 2*T) && (ly < CELL_H - T))
          || (segs[2] && lower && (lx >= T) && (lx < 2*T))
          || (segs[1] && upper && (lx >= T) && (lx < 2*T))
          || (segs[0] && gx && (ly >= MID - T/2) && (ly < MID - T/2 + T));

    // col < COLS drops the partial cell when H_ACTIVE is not a multiple of CELL_W.
    drawn = active && (col < COLS) && (k < DEPTH) && (k < 32'(shadow_cnt));

    bg = image ? 12'h00F : 12'h000;
    fg = image ? 12'h000 : 12'hFFF;
`ifdef TOS_HIGHLIGHT_EN
    if ((shadow_cnt != '0) && (k == 32'(shadow_cnt) - 1)) fg = 12'hF00;
`else
`endif

    if (!active)               rgb = '0;
    else if (drawn && seg_on)  rgb = fg;
    else                       rgb = bg;

    count_sat = (32'(count) > DEPTH) ? CW'(DEPTH) : count;
    load_now  = (h_cnt == '0) && (v_cnt == V_LOAD) && load_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      vga_h_sync  <= !SYNC_POL;
      vga_v_sync  <= !SYNC_POL;
      vga_R       <= '0;
      vga_G       <= '0;
      vga_B       <= '0;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
      shadow_num  <= '0;
      shadow_cnt  <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      vga_h_sync  <= hs_on ? SYNC_POL : !SYNC_POL;
      vga_v_sync  <= vs_on ? SYNC_POL : !SYNC_POL;
      {vga_R, vga_G, vga_B} <= rgb;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);

      load_ack <= load_now;
      if (load_now) begin
        shadow_num <= numbers;
        shadow_cnt <= count_sat;
      end
    end
  end

endmodule
